display_link_tx: RTL and testbench

Serial transmitter for the display-CPLD link: accepts a parallel binary value on the host side and shifts it out MSB-first as a framed bit stream (`sclk`, `sdat`, `sclr`) to the display CPLD. The display CPLD clocks its serial double-dabble registers on `sclk` rising edges and drives the 7-segment digits. This block sits in the host-side FPGA/CPLD. It owns clock division, the frame clear, value clamping and the load handshake.

---
 rtl/display_link_tx.sv | 164 ++++++++++++++++
 tb/tb_display_link_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/display_link_tx.sv
// display_link_tx: framed serial transmitter for the display-CPLD link.
// Clamps a binary value to the displayable range and shifts it out MSB-first.
//
// Ports:
//   clk    in            system clock, rising edge
//   rst    in            asynchronous active-high reset
//   start  in            send request, accepted only while ready=1
//   data   in  [WIDTH]   unsigned value, captured on acceptance
//   ready  out           idle and able to accept start
//   done   out           one-cycle pulse at frame completion
//   sclk   out           link shift clock (receiver samples on rise)
//   sdat   out           link serial data, MSB first
//   sclr   out           frame clear for the receiver digit registers
module display_link_tx #(
    parameter int WIDTH   = 10,
    parameter int DIGITS  = 3,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             done,
    output logic             sclk,
    output logic             sdat,
    output logic             sclr
);

    localparam int MAX_VALUE = (10 ** DIGITS) - 1;
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
    localparam logic [7:0] DLAST = 8'(CLK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [7:0]       div_q, div_d;
    logic             ph_q, ph_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             sclk_q, sclk_d;
    logic             sdat_q, sdat_d;
    logic             sclr_q, sclr_d;

    logic             half_end;
    logic             slot_end;
    logic [WIDTH-1:0] clamped;

    assign clamped  = (data > MAX_V) ? MAX_V : data;
    // ph_q marks the second half of a 2D-cycle slot.
    assign half_end = (div_q == DLAST);
    assign slot_end = half_end && ph_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        ph_d    = ph_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        sclk_d  = sclk_q;
        sdat_d  = sdat_q;
        sclr_d  = sclr_q;

        // Divider only runs inside a frame; a slot end wraps it back to
        // div=0, ph=0, which is also the state-entry value.
        if (state_q != S_IDLE) begin
            if (half_end) begin
                div_d = 8'd0;
                ph_d  = ~ph_q;
            end else begin
                div_d = div_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    sh_d    = clamped;
                    cnt_d   = CNT_TOP;
                    ready_d = 1'b0;
                    sclr_d  = 1'b1;
                    div_d   = 8'd0;
                    ph_d    = 1'b0;
                end
            end
            S_CLEAR: begin
                if (slot_end) begin
                    state_d = S_SHIFT;
                    sclr_d  = 1'b0;
                    sdat_d  = sh_q[WIDTH-1];
                end
            end
            S_SHIFT: begin
                if (half_end && !ph_q) begin
                    sclk_d = 1'b1;
                end else if (slot_end) begin
                    sclk_d = 1'b0;
                    sh_d   = sh_q << 1;
                    if (cnt_q == '0) begin
                        state_d = S_HOLD;
                        sdat_d  = 1'b0;
                    end else begin
                        cnt_d  = cnt_q - 1'b1;
                        // Next MSB is presented at the slot boundary.
                        sdat_d = sh_q[WIDTH-2];
                    end
                end
            end
            S_HOLD: begin
                if (slot_end) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= 8'd0;
            ph_q    <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdat_q  <= 1'b0;
            sclr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ph_q    <= ph_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            sdat_q  <= sdat_d;
            sclr_q  <= sclr_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign sclk  = sclk_q;
    assign sdat  = sdat_q;
    assign sclr  = sclr_q;

endmodule

// File: tb/tb_display_link_tx.sv
// tb_display_link_tx: self-checking bench for display_link_tx.
// Two instances: default divider (a) and CLK_DIV=1 (b).
module tb_display_link_tx;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_a = 1'b0;
    logic         start_b = 1'b0;
    logic [W-1:0] data_a = '0;
    logic [W-1:0] data_b = '0;
    logic ready_a, done_a, sclk_a, sdat_a, sclr_a;
    logic ready_b, done_b, sclk_b, sdat_b, sclr_b;

    int cmp = 0;
    int bad = 0;

    display_link_tx #(.WIDTH(10), .DIGITS(3), .CLK_DIV(4)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .data(data_a),
        .ready(ready_a), .done(done_a), .sclk(sclk_a),
        .sdat(sdat_a), .sclr(sclr_a)
    );

    display_link_tx #(.WIDTH(10), .DIGITS(3), .CLK_DIV(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .data(data_b),
        .ready(ready_b), .done(done_b), .sclk(sclk_b),
        .sdat(sdat_b), .sclr(sclr_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           sel;
        int unsigned  din;
        logic [W-1:0] bits;
    } vec_t;

    vec_t vecs[6];

    // {ready,done,sclk,sdat,sclr}
    function automatic logic [4:0] outs(input int sel);
        if (sel == 0) return {ready_a, done_a, sclk_a, sdat_a, sclr_a};
        return {ready_b, done_b, sclk_b, sdat_b, sclr_b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic s);
        if (sel == 0) start_a = s;
        else start_b = s;
    endtask

    // Drives one frame and checks every cycle against the timing rules:
    // clear for 2D cycles, W slots of 2D cycles (sclk high in the second
    // half), 2D hold cycles, then done with ready in cycle 2D(W+2)+1.
    task automatic frame(input int sel, input int unsigned d,
                         input int pulse_n, input bit keep,
                         output logic [W-1:0] rxo);
        int D, L, k, pos, rises, nclr;
        int unsigned cv;
        logic [4:0] e, o;
        logic prev;
        logic [W-1:0] rx;
        D = (sel == 0) ? 4 : 1;
        L = 2 * D * (W + 2);
        cv = (d > 999) ? 999 : d;
        rises = 0;
        nclr = 0;
        rx = '0;
        prev = 1'b0;
        @(negedge clk);
        if (sel == 0) data_a = d[W-1:0];
        else data_b = d[W-1:0];
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, keep);
        for (int n = 1; n <= L + 1; n++) begin
            if (n > 1) begin
                @(posedge clk);
                #1;
            end
            e = 5'b0;
            e[0] = (n <= 2 * D);
            if (n > 2 * D && n <= 2 * D * (W + 1)) begin
                k = (n - 1) / (2 * D) - 1;
                pos = (n - 1) % (2 * D);
                e[2] = (pos >= D);
                e[1] = ((cv >> (W - 1 - k)) & 1) != 0;
            end
            e[4] = (n == L + 1);
            e[3] = (n == L + 1);
            o = outs(sel);
            chk($sformatf("dut%0d d=%0d cyc%0d", sel, d, n),
                {27'b0, o}, {27'b0, e});
            if (o[0] && !o[2] && rises == 0) nclr++;
            if (o[2] && !prev) begin
                rises++;
                rx = {rx[W-2:0], o[1]};
            end
            prev = o[2];
            if (n == pulse_n) set_start(sel, 1'b1);
            if (n == pulse_n + 1) set_start(sel, 1'b0);
        end
        chk("sclk_rises", rises, W);
        chk("sclr_cycles", nclr, 2 * D);
        chk("stream_vs_model", {22'b0, rx}, cv);
        rxo = rx;
    endtask

    task automatic idle_cycles(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk(nm, {22'b0, outs(0), outs(1)}, {22'b0, 5'b10000, 5'b10000});
        end
    endtask

    logic [W-1:0] rxv;

    initial begin
        vecs[0] = '{0, 937,  10'b1110101001};
        vecs[1] = '{0, 1023, 10'b1111100111};
        vecs[2] = '{0, 999,  10'b1111100111};
        vecs[3] = '{0, 0,    10'b0000000000};
        vecs[4] = '{0, 5,    10'b0000000101};
        vecs[5] = '{1, 512,  10'b1000000000};

        // asynchronous reset with no clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_async_a", {27'b0, outs(0)}, {27'b0, 5'b10000});
        chk("rst_async_b", {27'b0, outs(1)}, {27'b0, 5'b10000});
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(200, "idle_after_reset");

        // table-driven frames
        foreach (vecs[i]) begin
            frame(vecs[i].sel, vecs[i].din, -1, 1'b0, rxv);
            chk($sformatf("table%0d_bits", i), {22'b0, rxv},
                {22'b0, vecs[i].bits});
            repeat (2) @(posedge clk);
        end

        // start pulsed mid-frame is ignored
        frame(0, 300, 40, 1'b0, rxv);
        idle_cycles(5, "no_second_frame");

        // start held through done: back-to-back with no gap
        frame(0, 421, -1, 1'b1, rxv);
        frame(0, 77, -1, 1'b0, rxv);
        idle_cycles(3, "after_b2b");

        // reset in cycle 50 abandons the frame
        @(negedge clk);
        data_a = 10'd937;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (49) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_frame", {27'b0, outs(0)}, {27'b0, 5'b10000});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(100, "no_done_after_rst");
        frame(0, 5, -1, 1'b0, rxv);
        chk("post_rst_bits", {22'b0, rxv}, {22'b0, 10'b0000000101});

        // randomized frames against the model
        for (int i = 0; i < 10; i++) begin
            frame(i % 2, $urandom_range(0, 1023), -1, 1'b0, rxv);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
